// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter with session high score and new-best flag.
// Ports: Clock, Reset (async, active-high), game_over, inc -> score_bcd, high_bcd, rollover, saturated, new_best.
module bcd_score_counter #(
    parameter int DIGITS   = 3,
    parameter bit SATURATE = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  game_over,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic                  rollover,
    output logic                  saturated,
    output logic                  new_best
);

    function automatic logic is_nines(input logic [4*DIGITS-1:0] v);
        logic r;
        r = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            r = r & (v[4*k +: 4] == 4'd9);
        end
        return r;
    endfunction

    logic [4*DIGITS-1:0] inc_val;
    logic [4*DIGITS-1:0] score_d;
    logic                all_nines;
    logic                rollover_d;
    logic                sat_d;
    logic                hi_upd;

    // Ripple carry: a scalar carry walks up the digits so the whole
    // chain resolves combinationally within one cycle.
    always_comb begin
        logic c;
        c       = 1'b1;
        inc_val = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!c) begin
                inc_val[4*k +: 4] = score_bcd[4*k +: 4];
            end else if (score_bcd[4*k +: 4] == 4'd9) begin
                inc_val[4*k +: 4] = 4'd0;
            end else begin
                inc_val[4*k +: 4] = score_bcd[4*k +: 4] + 4'd1;
            end
            c = c & (score_bcd[4*k +: 4] == 4'd9);
        end
        all_nines = c;
    end

    always_comb begin
        score_d    = score_bcd;
        rollover_d = 1'b0;
        if (game_over) begin
            score_d = '0;
        end else if (inc) begin
            if (!all_nines) begin
                score_d = inc_val;
            end else if (!SATURATE) begin
                score_d    = '0;
                rollover_d = 1'b1;
            end
        end
    end

    // Saturation is a level tied to the score sitting at all-nines; it
    // rises on the edge the score first lands there and clears with it.
    assign sat_d  = SATURATE && is_nines(score_d);

    // Packed BCD with valid nibbles orders exactly like its decimal value.
    assign hi_upd = score_bcd > high_bcd;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            score_bcd <= '0;
            high_bcd  <= '0;
            rollover  <= 1'b0;
            saturated <= 1'b0;
            new_best  <= 1'b0;
        end else begin
            score_bcd <= score_d;
            rollover  <= rollover_d;
            saturated <= sat_d;
            if (hi_upd) begin
                high_bcd <= score_bcd;
            end
            if (game_over) begin
                new_best <= 1'b0;
            end else if (hi_upd) begin
                new_best <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Scoreboard bench for bcd_score_counter: three configurations share stimulus.
// Decimal reference model predicts each edge; a negedge monitor checks outputs.
module tb_bcd_score_counter;

    typedef struct packed {
        logic [23:0] s;
        logic [23:0] h;
        logic        ro;
        logic        sa;
        logic        nb;
    } exp_t;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic game_over = 1'b0;
    logic inc = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  s0, h0, s1, h1;
    logic [11:0] s2, h2;
    logic        ro [3];
    logic        sa [3];
    logic        nb [3];
    logic [23:0] act_s [3];
    logic [23:0] act_h [3];

    bcd_score_counter #(.DIGITS(2), .SATURATE(1'b1)) u_s2 (
        .Clock(clk), .Reset(Reset), .game_over(game_over), .inc(inc),
        .score_bcd(s0), .high_bcd(h0),
        .rollover(ro[0]), .saturated(sa[0]), .new_best(nb[0]));

    bcd_score_counter #(.DIGITS(2), .SATURATE(1'b0)) u_w2 (
        .Clock(clk), .Reset(Reset), .game_over(game_over), .inc(inc),
        .score_bcd(s1), .high_bcd(h1),
        .rollover(ro[1]), .saturated(sa[1]), .new_best(nb[1]));

    bcd_score_counter #(.DIGITS(3), .SATURATE(1'b0)) u_w3 (
        .Clock(clk), .Reset(Reset), .game_over(game_over), .inc(inc),
        .score_bcd(s2), .high_bcd(h2),
        .rollover(ro[2]), .saturated(sa[2]), .new_best(nb[2]));

    assign act_s[0] = {16'd0, s0};
    assign act_s[1] = {16'd0, s1};
    assign act_s[2] = {12'd0, s2};
    assign act_h[0] = {16'd0, h0};
    assign act_h[1] = {16'd0, h1};
    assign act_h[2] = {12'd0, h2};

    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int dg [3] = '{2, 2, 3};
    bit st [3] = '{1'b1, 1'b0, 1'b0};
    int ms [3] = '{0, 0, 0};
    int mh [3] = '{0, 0, 0};
    bit mro [3] = '{0, 0, 0};
    bit msa [3] = '{0, 0, 0};
    bit mnb [3] = '{0, 0, 0};

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [23:0] a, input logic [23:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, a, e);
        end
    endtask

    task automatic push(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Reference: plain decimal arithmetic on the score value.
    task automatic model(input bit go, input bit in, input bit rs);
        for (int i = 0; i < 3; i++) begin
            int s;
            int mx;
            exp_t e;
            s  = ms[i];
            mx = 1;
            for (int k = 0; k < dg[i]; k++) mx = mx * 10;
            mx = mx - 1;
            if (rs) begin
                ms[i] = 0; mh[i] = 0;
                mro[i] = 0; msa[i] = 0; mnb[i] = 0;
            end else begin
                if (s > mh[i]) begin
                    mh[i] = s;
                    if (!go) mnb[i] = 1;
                end
                if (go) mnb[i] = 0;
                mro[i] = 0;
                if (go) begin
                    ms[i] = 0;
                    msa[i] = 0;
                end else if (in) begin
                    if (s == mx) begin
                        if (st[i]) msa[i] = 1;
                        else begin
                            ms[i] = 0;
                            mro[i] = 1;
                        end
                    end else begin
                        ms[i] = s + 1;
                        if (st[i] && s + 1 == mx) msa[i] = 1;
                    end
                end
            end
            e.s  = to_bcd(ms[i]);
            e.h  = to_bcd(mh[i]);
            e.ro = mro[i];
            e.sa = msa[i];
            e.nb = mnb[i];
            push(i, e);
        end
    endtask

    task automatic cyc(input bit go, input bit in, input bit rs);
        @(negedge clk);
        #1;
        game_over = go;
        inc = in;
        if (rs && !Reset) begin
            Reset = 1'b1;
            #1;
            for (int i = 0; i < 3; i++) begin
                chk("async_rst_score", i, act_s[i], 24'd0);
                chk("async_rst_high", i, act_h[i], 24'd0);
                chk("async_rst_flags", i,
                    {21'd0, ro[i], sa[i], nb[i]}, 24'd0);
            end
        end
        Reset = rs;
        model(go, in, rs);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                exp_t e;
                bit have;
                have = 1'b0;
                case (i)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                endcase
                if (have) begin
                    chk("score", i, act_s[i], e.s);
                    chk("high", i, act_h[i], e.h);
                    chk("rollover", i, {23'd0, ro[i]}, {23'd0, e.ro});
                    chk("saturated", i, {23'd0, sa[i]}, {23'd0, e.sa});
                    chk("new_best", i, {23'd0, nb[i]}, {23'd0, e.nb});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc(0, 0, 1);
        cyc(0, 0, 0);
        repeat (12) begin
            cyc(0, 1, 0);
            cyc(0, 0, 0);
        end
        repeat (2) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (1000) cyc(0, 1, 0);
        repeat (2) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (25) cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(1, 1, 0);
        repeat (3) cyc(0, 1, 0);
        repeat (300) begin
            bit g;
            bit n;
            g = ($urandom % 40) == 0;
            n = ($urandom % 4) != 0;
            cyc(g, n, 0);
        end
        repeat (47) cyc(0, 1, 0);
        repeat (2) cyc(0, 1, 1);
        cyc(0, 1, 0);
        repeat (50) cyc(0, 1, 0);
        repeat (2) @(negedge clk);
        #2;
        chk("drain", 0, 24'(q0.size() + q1.size() + q2.size()), 24'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_score_counter.md
Name: bcd_score_counter

Overview:
Parametrised multi-digit BCD score counter for the game datapath. Each `inc` pulse adds one point and ripple-carries across all digits in a single cycle. The block also tracks a session high score and flags a new best. Outputs drive the hex-display decoders directly, one nibble per digit, and replace chains of single-digit counters.

Parameters:
DIGITS, 3, number of BCD digits (1..6); the score range is 0 .. 10^DIGITS-1.
SATURATE, 1, 1 = hold at all-nines on overflow; 0 = wrap to zero and pulse `rollover`.

Ports:
Clock  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-high; clears all state.
game_over  input  1  synchronous clear of the current score, level-sensitive.
inc  input  1  add one point this cycle; sampled on the rising edge.
score_bcd  output  4*DIGITS  current score; digit 0 (units) is in bits [3:0].
high_bcd  output  4*DIGITS  session high score, same packing.
rollover  output  1  one-cycle pulse on wrap (SATURATE=0 only).
saturated  output  1  level high while the score is held at all-nines (SATURATE=1 only).
new_best  output  1  level high once the current run has exceeded the stored high score.

Behaviour:
- Reset asserted, asynchronous: `score_bcd`=0, `high_bcd`=0, `rollover`=0, `saturated`=0, `new_best`=0. Reset dominates every other input.
- All other updates occur on the rising edge of `Clock`. All outputs are registered.
- Priority per edge: `game_over` > `inc`.
- `game_over`=1:
  - `score_bcd` <= 0; `rollover` <= 0; `saturated` <= 0; `new_best` <= 0.
  - High-score capture still occurs this edge, using the pre-clear score.
- `inc`=1, `game_over`=0: BCD increment with full ripple, latency 1 cycle.
  - Digit k increments only if digits 0..k-1 are all 9.
  - Any digit at 9 that receives a carry becomes 0.
  - Only values 0-9 ever appear in any nibble.
- Overflow: all digits are 9 and `inc`=1.
  - SATURATE=1: score unchanged; `saturated` <= 1 from that edge. `saturated` also asserts on the edge the score first reaches all-nines.
  - SATURATE=0: score <= 0; `rollover` <= 1 for exactly one cycle. A second `inc` on the next cycle increments to 1 and drops `rollover`.
- `rollover` is 0 in every cycle that is not a wrap edge.
- `saturated` stays 0 when SATURATE=0. `rollover` stays 0 when SATURATE=1.
- `inc`=0, `game_over`=0: score holds; `rollover` <= 0.
- High score: on each edge with Reset low, if the registered `score_bcd` > `high_bcd` (unsigned compare of BCD values), then `high_bcd` <= `score_bcd`.
  - As a result, `high_bcd` lags `score_bcd` by one cycle.
  - `high_bcd` is cleared only by Reset, never by `game_over`.
- `new_best` <= 1 on any edge where the high-score update fires and `game_over`=0. It holds until `game_over` or Reset.
- Wrap does not reduce `high_bcd`. After a wrap, the high score is not overtaken again until the score exceeds it.
- `inc` held high counts one point per cycle. There is no edge detection inside the block; pulse shaping is upstream.
- `inc` and `game_over` are assumed synchronous to `Clock`. There is no internal synchroniser.
- Reset deasserting mid-run: the first active edge behaves as if from score 0.

Test Plan:
- DIGITS=2, SATURATE=1: Reset, then 12 single-cycle `inc` pulses -> `score_bcd`=8'h12 one cycle after the last pulse. No nibble is ever >9; `high_bcd`=8'h12 one cycle later; `new_best`=1.
- DIGITS=2: from 8'h09, one `inc` -> 8'h10 (carry). From 8'h99 with SATURATE=1, `inc` held 3 cycles -> score stays 8'h99, `saturated`=1, `rollover`=0.
- DIGITS=2, SATURATE=0: from 8'h99, one `inc` -> 8'h00 and `rollover`=1 for one cycle. `inc` on the following cycle -> 8'h01, `rollover`=0; `high_bcd` remains 8'h99.
- Score 8'h25 and `high_bcd` 8'h25 (equal), then `game_over` and `inc` together for one cycle -> `score_bcd`=0, `high_bcd`=8'h25, `new_best`=0. Three further `inc` -> `score_bcd`=8'h03, `high_bcd` unchanged, `new_best`=0.
- Reset asserted asynchronously between clock edges with score 8'h47 and `high_bcd` 8'h47 -> all outputs 0 immediately, before the next edge. `inc` during Reset has no effect.
- DIGITS=3: 1000 consecutive `inc` from 0 with SATURATE=0 -> one `rollover` pulse exactly at the 12'h999->12'h000 edge. Compare against a reference decimal count every cycle.
